iter_mult_div: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with integrated HI/LO registers, for the pipelined CPU.
//  It replaces the single-cycle combinational MultDiv + LoHiRegister pair.

---
 rtl/iter_mult_div.sv | 161 ++++++++++++++++
 tb/tb_iter_mult_div.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_mult_div.sv
// Multi-cycle multiply/divide unit with HI/LO registers: radix-2 shift-add multiply,
// restoring divide, one bit per clock, start/busy/done handshake.
module iter_mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wen,
  input  logic             lo_wen,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  // Datapath: acc holds {upper, multiplier} for multiply, {remainder, dividend/quotient} for divide
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               dbz;

  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic               b_zero;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] acc_step;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v,
                                             input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
  endfunction

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    b_zero    = (b == '0);
    abs_a     = abs_w(a, is_signed);
    abs_b     = abs_w(b, is_signed);
  end

  // One iteration: add-then-shift for multiply, shift-then-trial-subtract for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc[0]}}};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    if (is_div) begin
      if (div_diff[WIDTH+1])
        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Operand capture at the start edge, then one step per CALC edge
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      is_div  <= op[1];
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      dbz     <= op[1] & b_zero;
      opnd    <= op[1] ? abs_b : abs_a;
      if (op[1] && b_zero)
        acc <= {a, {WIDTH{1'b1}}};
      else if (op[1])
        acc <= {{WIDTH{1'b0}}, abs_a};
      else
        acc <= {{WIDTH{1'b0}}, abs_b};
    end else if (state == S_CALC) begin
      acc <= acc_step;
    end
  end

  // Control, HI/LO writeback and MTHI/MTLO
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= (op[1] && b_zero) ? S_FIN : S_CALC;
            cnt   <= '0;
          end else begin
            if (hi_wen) hi_r <= wdata;
            if (lo_wen) lo_r <= wdata;
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) state <= S_FIN;
        end
        S_FIN: begin
          state  <= S_IDLE;
          done_r <= 1'b1;
          dbz_r  <= dbz;
          if (dbz) begin
            {hi_r, lo_r} <= acc;
          end else if (is_div) begin
            hi_r <= neg_rem ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
            lo_r <= neg_res ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
          end else begin
            {hi_r, lo_r} <= neg_res ? neg_2w(acc) : acc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule

// File: tb/tb_iter_mult_div.sv
// Bench for iter_mult_div: arithmetic reference model compared every cycle, plus
// directed vectors with hand-computed results.
module tb_iter_mult_div;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_wen = 1'b0;
  logic         lo_wen = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  iter_mult_div #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the instruction semantics
  function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rh, output logic [31:0] rl, output logic z);
    logic [63:0] p;
    longint sp;
    int q, r;
    z = 1'b0;
    p = '0;
    case (o)
      2'b00: begin sp = longint'($signed(x)) * longint'($signed(y)); p = sp; end
      2'b01: p = {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) begin z = 1'b1; p = {x, 32'hFFFFFFFF}; end
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
        else begin
          q = $signed(x) / $signed(y);
          r = $signed(x) % $signed(y);
          p = {32'(r), 32'(q)};
        end
      end
      default: begin
        if (y == 0) begin z = 1'b1; p = {x, 32'hFFFFFFFF}; end
        else p = {x % y, x / y};
      end
    endcase
    rh = p[63:32];
    rl = p[31:0];
  endfunction

  // Timing model: result lands WIDTH+1 edges after the start edge (1 edge for divide by zero)
  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  logic        r_dbz = 1'b0;
  int          m_left = 0;
  logic [31:0] th, tl;
  logic        tz;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          model_op(op, a, b, th, tl, tz);
          r_hi <= th; r_lo <= tl; r_dbz <= tz;
          m_left <= tz ? 1 : W + 1;
          m_busy <= 1'b1;
        end else begin
          if (hi_wen) m_hi <= wdata;
          if (lo_wen) m_lo <= wdata;
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_dbz <= r_dbz;
        m_hi <= r_hi; m_lo <= r_lo;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("div_by_zero", div_by_zero, m_dbz);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // Called at a negedge; returns at the negedge where done is seen
  task automatic wait_done(input int glitch_at, output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; op = 2'b00; a = '0; b = '0; end
      if (n == glitch_at) begin start = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1; end
      if (n == glitch_at + 1) start = 1'b0;
      if (done) begin lat = n; break; end
      if (busy) busy_cyc++;
    end
    if (lat == 0) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done within 80 cycles, required done");
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int glitch_at, output int lat, output int busy_cyc);
    start = 1'b1; op = o; a = x; b = y;
    wait_done(glitch_at, lat, busy_cyc);
  endtask

  int lat, bc;
  bit done_seen;

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    run_op(2'b00, 32'hFFFFFFFD, 32'd7, -1, lat, bc);
    check("mult_lat", lat, 34);
    check("mult_busy_cycles", bc, 33);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);

    @(negedge clk);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, lat, bc);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, -1, lat, bc);
    check("b2b_div_lat", lat, 34);
    check("b2b_div_lo", lo, 32'hFFFFFFFD);
    check("b2b_div_hi", hi, 32'hFFFFFFFF);

    @(negedge clk);
    run_op(2'b11, 32'd100, 32'd0, -1, lat, bc);
    check("dbz_lat", lat, 2);
    check("dbz_flag", div_by_zero, 1'b1);
    check("dbz_hi", hi, 32'h00000064);
    check("dbz_lo", lo, 32'hFFFFFFFF);

    @(negedge clk);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, lat, bc);
    check("minneg1_lo", lo, 32'h80000000);
    check("minneg1_hi", hi, 32'h00000000);
    check("minneg1_dbz", div_by_zero, 1'b0);

    @(negedge clk);
    run_op(2'b00, 32'd5, 32'd6, 10, lat, bc);
    check("ignored_start_lat", lat, 34);
    check("ignored_start_hi", hi, 32'h0);
    check("ignored_start_lo", lo, 32'h0000001E);

    @(negedge clk);
    run_op(2'b11, 32'd1000, 32'd7, -1, lat, bc);
    check("divu_lo", lo, 32'd142);
    check("divu_hi", hi, 32'd6);

    @(negedge clk);
    run_op(2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, -1, lat, bc);
    check("div_negneg_lo", lo, 32'd3);
    check("div_negneg_hi", hi, 32'hFFFFFFFF);

    @(negedge clk);
    run_op(2'b00, 32'h80000000, 32'h80000000, -1, lat, bc);
    check("mult_min_hi", hi, 32'h40000000);
    check("mult_min_lo", lo, 32'h00000000);

    // Reset in the middle of a MULTU
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd1234; b = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("abort_no_done", done_seen, 1'b0);

    hi_wen = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    hi_wen = 1'b0;
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo", lo, 32'h0);

    hi_wen = 1'b1; lo_wen = 1'b1; wdata = 32'hCAFEF00D;
    @(negedge clk);
    hi_wen = 1'b0; lo_wen = 1'b0;
    check("mt_both_hi", hi, 32'hCAFEF00D);
    check("mt_both_lo", lo, 32'hCAFEF00D);

    // start wins over MTHI; MTLO while busy is dropped
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3; hi_wen = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; hi_wen = 1'b0; op = 2'b00; a = '0; b = '0;
    check("start_prio_hi", hi, 32'hCAFEF00D);
    lo_wen = 1'b1; wdata = 32'h11111111;
    @(negedge clk);
    lo_wen = 1'b0;
    check("mt_busy_lo", lo, 32'hCAFEF00D);
    wait_done(-1, lat, bc);
    check("prio_mult_hi", hi, 32'h0);
    check("prio_mult_lo", lo, 32'd6);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
